// File: rtl/lcd_pix_serializer_if.sv
// rtl/lcd_pix_serializer_if.sv - GPU word stream and PHY byte stream bundle
// master drives words in and consumes bytes; slave is the serializer.
interface lcd_pix_serializer_if #(
  parameter int BYTES = 2
);
  logic [8*BYTES-1:0] gpu_data;
  logic               gpu_sof;
  logic               gpu_valid;
  logic               gpu_ready;
  logic [7:0]         phy_data;
  logic               phy_rs;
  logic               phy_valid;
  logic               phy_ready;

  modport master (
    output gpu_data, gpu_sof, gpu_valid, phy_ready,
    input  gpu_ready, phy_data, phy_rs, phy_valid
  );

  modport slave (
    input  gpu_data, gpu_sof, gpu_valid, phy_ready,
    output gpu_ready, phy_data, phy_rs, phy_valid
  );
endinterface

// File: rtl/lcd_pix_serializer.sv
// rtl/lcd_pix_serializer.sv - pixel word to LCD byte stream serializer
// Inserts a write-memory command before each frame and counts pixels per frame.
module lcd_pix_serializer #(
  parameter int          BYTES    = 2,
  parameter int          CNT_W    = 17,
  parameter logic [7:0]  CMD_BYTE = 8'h2c
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_swap,
  input  logic [CNT_W-1:0]     cfg_npix,
  lcd_pix_serializer_if.slave  bus,
  output logic                 frame_done,
  output logic                 err_short,
  output logic [CNT_W-1:0]     pix_cnt
);

  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {ST_EMPTY, ST_CMD, ST_DATA} state_t;

  state_t             state_q, state_d;
  logic [8*BYTES-1:0] data_q, data_d;
  logic               swap_q, swap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic               frame_done_q, frame_done_d;
  logic               err_short_q, err_short_d;

  logic               accept;
  logic               phy_hs;
  logic               pix_done;
  logic [IDX_W-1:0]   sel;

  assign accept   = bus.gpu_valid & bus.gpu_ready;
  assign phy_hs   = bus.phy_valid & bus.phy_ready;
  assign pix_done = (state_q == ST_DATA) & phy_hs & (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      swap_q       <= 1'b0;
      idx_q        <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      swap_q       <= swap_d;
      idx_q        <= idx_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
      err_short_q  <= err_short_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    swap_d       = swap_q;
    idx_d        = idx_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    err_short_d  = 1'b0;

    case (state_q)
      ST_CMD: begin
        if (phy_hs) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (phy_hs) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: ;
    endcase

    // A new word can only be taken when the register is empty or draining its last byte.
    if (accept) begin
      data_d  = bus.gpu_data;
      swap_d  = cfg_swap;
      idx_d   = '0;
      state_d = bus.gpu_sof ? ST_CMD : ST_DATA;
    end

    if (pix_done) begin
      pix_cnt_d = pix_cnt_q + CNT_W'(1);
      if ((cfg_npix != '0) && (pix_cnt_d == cfg_npix)) begin
        frame_done_d = 1'b1;
        pix_cnt_d    = '0;
      end
    end

    // Short-frame check sees the count after the old pixel has been credited.
    if (accept && bus.gpu_sof) begin
      err_short_d = (cfg_npix != '0) && (pix_cnt_d != '0);
      pix_cnt_d   = '0;
    end
  end

  always_comb begin
    bus.gpu_ready = 1'b0;
    bus.phy_valid = 1'b0;
    bus.phy_rs    = 1'b1;
    bus.phy_data  = '0;
    sel           = swap_q ? idx_q : (LAST_IDX - idx_q);

    case (state_q)
      ST_EMPTY: begin
        bus.gpu_ready = 1'b1;
      end
      ST_CMD: begin
        bus.phy_valid = 1'b1;
        bus.phy_rs    = 1'b0;
        bus.phy_data  = CMD_BYTE;
      end
      ST_DATA: begin
        bus.phy_valid = 1'b1;
        for (int i = 0; i < BYTES; i++) begin
          if (sel == IDX_W'(i)) begin
            bus.phy_data = data_q[8*i +: 8];
          end
        end
        bus.gpu_ready = (idx_q == LAST_IDX) & bus.phy_ready;
      end
      default: ;
    endcase
  end

  assign frame_done = frame_done_q;
  assign err_short  = err_short_q;
  assign pix_cnt    = pix_cnt_q;

endmodule

// File: tb/tb_lcd_pix_serializer.sv
// tb/tb_lcd_pix_serializer.sv - randomized self-checking bench for lcd_pix_serializer
// A byte-queue model predicts the stream, handshakes and frame counters.
module tb_lcd_pix_serializer;

  localparam int BYTES = 3;
  localparam int CNT_W = 17;
  localparam logic [7:0] CMD = 8'h2c;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_swap = 1'b0;
  logic [CNT_W-1:0] cfg_npix = '0;
  logic             frame_done;
  logic             err_short;
  logic [CNT_W-1:0] pix_cnt;

  lcd_pix_serializer_if #(.BYTES(BYTES)) bus ();

  lcd_pix_serializer #(.BYTES(BYTES), .CNT_W(CNT_W), .CMD_BYTE(CMD)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_swap   (cfg_swap),
    .cfg_npix   (cfg_npix),
    .bus        (bus),
    .frame_done (frame_done),
    .err_short  (err_short),
    .pix_cnt    (pix_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_seen = 0;
  int err_seen = 0;

  logic [9:0] exp_q[$];   // {last byte of pixel, rs, data}
  logic [8:0] cap_q[$];   // consumed {rs, data}
  int         cap_cyc[$];
  logic [CNT_W-1:0] m_cnt;
  logic       m_done, m_err;
  bit         rdy_rand = 1'b0;
  logic       rdy_fixed = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.phy_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Model: every accepted word becomes its bytes in a queue; the DUT must show the queue head.
  initial begin
    logic       exp_rdy, nd, ne;
    logic [9:0] f;
    logic [7:0] b;
    int         sh;
    m_cnt  = '0;
    m_done = 1'b0;
    m_err  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        m_cnt  = '0;
        m_done = 1'b0;
        m_err  = 1'b0;
      end else begin
        chk("frame_done", frame_done, m_done);
        chk("err_short", err_short, m_err);
        chk("pix_cnt", pix_cnt, m_cnt);
        if (frame_done) done_seen++;
        if (err_short) err_seen++;
        chk("phy_valid", bus.phy_valid, exp_q.size() != 0);
        exp_rdy = (exp_q.size() == 0) ? 1'b1 : (exp_q[0][9] & exp_q[0][8] & bus.phy_ready);
        chk("gpu_ready", bus.gpu_ready, exp_rdy);
        if (bus.phy_valid && exp_q.size() != 0)
          chk("phy_byte", {bus.phy_rs, bus.phy_data}, exp_q[0][8:0]);
        nd = 1'b0;
        ne = 1'b0;
        if (bus.phy_valid && bus.phy_ready && exp_q.size() != 0) begin
          f = exp_q.pop_front();
          cap_q.push_back({bus.phy_rs, bus.phy_data});
          cap_cyc.push_back(cyc);
          if (f[9]) begin
            m_cnt++;
            if (cfg_npix != 0 && m_cnt == cfg_npix) begin
              nd    = 1'b1;
              m_cnt = '0;
            end
          end
        end
        if (bus.gpu_valid && bus.gpu_ready) begin
          if (bus.gpu_sof) begin
            ne    = (cfg_npix != 0) && (m_cnt != 0);
            m_cnt = '0;
            exp_q.push_back({1'b0, 1'b0, CMD});
          end
          for (int k = 0; k < BYTES; k++) begin
            sh = cfg_swap ? k : (BYTES - 1 - k);
            b  = 8'(bus.gpu_data >> (8 * sh));
            exp_q.push_back({(k == BYTES - 1), 1'b1, b});
          end
        end
        m_done = nd;
        m_err  = ne;
      end
    end
  end

  task automatic send_word(input logic [23:0] w, input logic sof, input logic sw);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    bus.gpu_data  = w;
    bus.gpu_sof   = sof;
    bus.gpu_valid = 1'b1;
    cfg_swap      = sw;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = bus.gpu_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    bus.gpu_valid = 1'b0;
    bus.gpu_sof   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] t1[4];
    logic [8:0] t2[12];
    logic [8:0] t6[4];
    int d0, e0, n, base;

    bus.gpu_valid = 1'b0;
    bus.gpu_sof   = 1'b0;
    bus.gpu_data  = '0;
    bus.phy_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_phy_valid", bus.phy_valid, 1'b0);
    chk("rst_phy_rs", bus.phy_rs, 1'b1);
    chk("rst_gpu_ready", bus.gpu_ready, 1'b1);
    chk("rst_pix_cnt", pix_cnt, 0);
    chk("rst_strobes", {frame_done, err_short}, 2'b00);
    @(posedge clk);
    #1;

    // sof word, MSB first: command then three data bytes
    t1 = '{9'h02c, 9'h1a5, 9'h15a, 9'h1c3};
    cap_q.delete();
    send_word(24'hA55AC3, 1'b1, 1'b0);
    drain();
    chk("t1_len", cap_q.size(), 4);
    for (int i = 0; i < 4 && i < cap_q.size(); i++) chk("t1_byte", cap_q[i], t1[i]);
    chk("t1_idle_valid", bus.phy_valid, 1'b0);
    chk("t1_idle_ready", bus.gpu_ready, 1'b1);

    // back-to-back LSB-first words: no bubble across 12 bytes
    t2 = '{9'h133, 9'h122, 9'h111, 9'h166, 9'h155, 9'h144,
           9'h199, 9'h188, 9'h177, 9'h1cc, 9'h1bb, 9'h1aa};
    cap_q.delete();
    cap_cyc.delete();
    send_word(24'h112233, 1'b0, 1'b1);
    send_word(24'h445566, 1'b0, 1'b1);
    send_word(24'h778899, 1'b0, 1'b1);
    send_word(24'hAABBCC, 1'b0, 1'b1);
    drain();
    chk("t2_len", cap_q.size(), 12);
    for (int i = 0; i < 12 && i < cap_q.size(); i++) chk("t2_byte", cap_q[i], t2[i]);
    if (cap_cyc.size() == 12) chk("t2_no_bubble", cap_cyc[11] - cap_cyc[0], 11);

    // two random frames under random backpressure
    cfg_npix = 17'd5;
    d0 = done_seen;
    e0 = err_seen;
    rdy_rand = 1'b1;
    for (int fr = 0; fr < 2; fr++) begin
      for (int p = 0; p < 5; p++) begin
        send_word(24'($urandom), (p == 0), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();
    rdy_rand = 1'b0;
    @(posedge clk);
    #1;
    chk("t3_done_cnt", done_seen - d0, 2);
    chk("t3_err_cnt", err_seen - e0, 1);

    // exact frame of four pixels
    cfg_npix = 17'd4;
    d0 = done_seen;
    e0 = err_seen;
    for (int p = 0; p < 4; p++) send_word(24'h010203 * (p + 1), (p == 0), 1'b0);
    drain();
    chk("t4_done_cnt", done_seen - d0, 1);
    chk("t4_pix_cnt", pix_cnt, 0);

    // short frame: three pixels then a new sof
    for (int p = 0; p < 3; p++) send_word(24'h0a0b0c + p, (p == 0), 1'b0);
    drain();
    chk("t5_no_err_after_full", err_seen - e0, 0);
    send_word(24'h123456, 1'b1, 1'b0);
    drain();
    chk("t5_err_cnt", err_seen - e0, 1);
    chk("t5_pix_cnt", pix_cnt, 1);

    cfg_npix = '0;
    d0 = done_seen;
    e0 = err_seen;
    for (int p = 0; p < 3; p++) send_word(24'h0d0e0f + p, (p == 0), 1'b1);
    send_word(24'h654321, 1'b1, 1'b0);
    drain();
    chk("t5_disabled_strobes", (done_seen - d0) + (err_seen - e0), 0);
    chk("t5_disabled_cnt", pix_cnt, 1);

    // reset while the second data byte is on the bus
    cfg_npix = 17'd4;
    cap_q.delete();
    base = 0;
    send_word(24'h5a6b7c, 1'b1, 1'b0);
    n = 0;
    while (cap_q.size() < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cap_q.size() < base + 2) chk("t6_wait_timeout", cap_q.size(), base + 2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_phy_valid", bus.phy_valid, 1'b0);
    chk("t6_gpu_ready", bus.gpu_ready, 1'b1);
    chk("t6_pix_cnt", pix_cnt, 0);
    chk("t6_strobes", {frame_done, err_short}, 2'b00);
    @(posedge clk);
    #1;

    t6 = '{9'h02c, 9'h10f, 9'h11e, 9'h12d};
    cap_q.delete();
    send_word(24'h0F1E2D, 1'b1, 1'b0);
    drain();
    chk("t6_len", cap_q.size(), 4);
    for (int i = 0; i < 4 && i < cap_q.size(); i++) chk("t6_byte", cap_q[i], t6[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
